mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_arb_streak_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// response owner encoding, fetch access size and streak counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int DEF_MAX_DM_STREAK = 2;

    // Fetches are always full-word reads.
    localparam logic [2:0] FUN3_WORD = 3'b010;

    // Counter width able to hold 0..max, never narrower than one bit.
    function automatic int streak_width(input int max);
        int w;
        w = $clog2(max + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and unified memory port signals around the arbiter.
// The slave modport is the arbiter; the master modport is the core plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [2:0]        dm_fun3;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_fun3;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_fun3,
        output dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_fun3,
        input  mem_rdata,
        output stall
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_fun3,
        input  dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_fun3,
        output mem_rdata,
        input  stall
    );

endinterface

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of data grants taken while a fetch is kept waiting.
// limit goes high once the count reaches MAX, handing the next slot to fetch.
module mem_arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_MAX_DM_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit
);

    localparam int             W       = streak_width(MAX);
    localparam logic [W-1:0]   MAX_CNT = W'(MAX);

    logic [W-1:0] count_reg;

    // Clear wins over increment; the count holds at MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_CNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign limit = (count_reg == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory.
// Data wins by default; after MAX_DM_STREAK data grants a waiting fetch gets one slot.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    logic   if_gnt;
    logic   dm_gnt;
    logic   streak_limit;
    logic   streak_inc;
    logic   streak_clr;
    owner_t resp_owner;
    owner_t owner_next;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_fun3;

    // Fetch only overtakes data when both are asking and the streak is used up.
    always_comb begin
        dm_gnt = bus.dm_req && !(bus.if_req && streak_limit);
        if_gnt = bus.if_req && !dm_gnt;
    end

    assign streak_inc = dm_gnt && bus.if_req;
    assign streak_clr = if_gnt || !bus.if_req;

    mem_arb_streak_ctr #(
        .MAX (MAX_DM_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .limit (streak_limit)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_fun3  = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.dm_we;
            mem_addr  = bus.dm_addr;
            mem_wdata = bus.dm_wdata;
            mem_fun3  = bus.dm_fun3;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = bus.if_addr;
            mem_fun3  = FUN3_WORD;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (dm_gnt) begin
            owner_next = OWN_DM;
        end else if (if_gnt) begin
            owner_next = OWN_IF;
        end
    end

    // One-deep response tracker: memory answers exactly one cycle after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_owner <= OWN_NONE;
        end else begin
            resp_owner <= owner_next;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_fun3  = mem_fun3;

    assign bus.if_valid  = (resp_owner == OWN_IF);
    assign bus.dm_valid  = (resp_owner == OWN_DM);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

    assign bus.stall     = bus.if_req && !if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// model: grant rules from request history, responses tracked from a shadow memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .MAX_DM_STREAK (MAXS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory behind the port: registered read, one cycle after mem_en.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    always @(negedge clk) begin
        if (rst) check("excl_gnt", {63'd0, bus.if_gnt & bus.dm_gnt}, 64'd0);
    end

    // Reference model state
    logic [DW-1:0] shadow [0:255];
    int            streak;
    bit            pend_if, pend_dm, pend_rd;
    logic [DW-1:0] pend_data;

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_fun3  = '0;
    endtask

    task automatic cycle(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd,
                         input logic [2:0] df, input string tag);
        bit egd, egi;
        @(posedge clk);
        #1;
        cyc++;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        bus.dm_fun3  = df;
        egd = dr && !(ir && (streak >= MAXS));
        egi = ir && !egd;
        #4;
        check("if_gnt",   {63'd0, bus.if_gnt}, {63'd0, egi});
        check("dm_gnt",   {63'd0, bus.dm_gnt}, {63'd0, egd});
        check("stall",    {63'd0, bus.stall},  {63'd0, ir && !egi});
        check("mem_en",   {63'd0, bus.mem_en}, {63'd0, egd || egi});
        check("mem_we",   {63'd0, bus.mem_we}, {63'd0, egd && dw});
        check("mem_addr", 64'(bus.mem_addr),  egd ? 64'(da) : (egi ? 64'(ia) : 64'd0));
        check("mem_wdata",64'(bus.mem_wdata), egd ? 64'(dd) : 64'd0);
        check("mem_fun3", 64'(bus.mem_fun3),  egd ? 64'(df) : (egi ? 64'(FUN3_WORD) : 64'd0));
        check("if_valid", {63'd0, bus.if_valid}, {63'd0, pend_if});
        check("dm_valid", {63'd0, bus.dm_valid}, {63'd0, pend_dm});
        if (pend_if) check("if_rdata", 64'(bus.if_rdata), 64'(pend_data));
        if (pend_dm && pend_rd) check("dm_rdata", 64'(bus.dm_rdata), 64'(pend_data));
        $display("cyc %0d %s ir=%0d dr=%0d we=%0d -> gi=%0d gd=%0d iv=%0d dv=%0d",
                 cyc, tag, ir, dr, dw, bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid);
        pend_if   = egi;
        pend_dm   = egd;
        pend_rd   = egi || (egd && !dw);
        pend_data = egd ? shadow[da[9:2]] : shadow[ia[9:2]];
        if (egd && dw) shadow[da[9:2]] = dd;
        if (!ir || egi) streak = 0;
        else if (egd && streak < MAXS) streak++;
    endtask

    task automatic model_reset();
        streak  = 0;
        pend_if = 1'b0;
        pend_dm = 1'b0;
        pend_rd = 1'b0;
    endtask

    // Reset pulse asserted mid-cycle, right where a response would be visible.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #1;
        cyc++;
        drive_idle();
        rst = 1'b0;
        #4;
        check("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
        check("rst_dm_valid", {63'd0, bus.dm_valid}, 64'd0);
        check("rst_mem_en",   {63'd0, bus.mem_en},   64'd0);
        $display("cyc %0d %s reset asserted dv=%0d", cyc, tag, bus.dm_valid);
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    logic [AW-1:0] ra, rda;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        drive_idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_if_valid", {63'd0, bus.if_valid}, 64'd0);
        check("init_dm_valid", {63'd0, bus.dm_valid}, 64'd0);
        check("init_stall",    {63'd0, bus.stall},    64'd0);
        #2;
        rst = 1'b1;

        for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, '0, '0, 3'b000, "idle");

        cycle(1, 32'h0, 0, 0, '0, '0, 3'b000, "fetch0");
        cycle(1, 32'h4, 0, 0, '0, '0, 3'b000, "fetch4");
        cycle(1, 32'h8, 0, 0, '0, '0, 3'b000, "fetch8");
        cycle(0, '0,    0, 0, '0, '0, 3'b000, "drain");

        for (int i = 0; i < 4; i++)
            cycle(1, 32'h20 + 32'(4 * i), 1, 0, 32'h40 + 32'(4 * i), '0, 3'b010, "both");
        cycle(0, '0, 0, 0, '0, '0, 3'b000, "drain");

        cycle(0, '0, 1, 1, 32'h10, 32'hDEADBEEF, 3'b010, "wr10");
        cycle(0, '0, 1, 0, 32'h10, '0,           3'b010, "rd10");
        cycle(0, '0, 0, 0, '0,     '0,           3'b000, "drain");

        cycle(0, '0, 1, 0, 32'h10, '0, 3'b010, "rd_pre_rst");
        reset_pulse("rst_mid");
        cycle(0, '0, 0, 0, '0, '0, 3'b000, "post_rst");
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h60 + 32'(4 * i), 1, 0, 32'h10, '0, 3'b010, "both_rst");

        for (int i = 0; i < 2000; i++) begin
            ra  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rda = {22'd0, 8'($urandom_range(0, 15)),  2'b00};
            cycle(($urandom_range(0, 3) != 0), ra,
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, rda,
                  $urandom, 3'($urandom_range(0, 7)), "rand");
        end
        cycle(0, '0, 0, 0, '0, '0, 3'b000, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
